// File: rtl/mult_share_arbiter.sv
// Round-robin front end that time-shares one parallel multiplier between NUM_REQ engines.
// A {valid, id} tag pipe matched to the multiplier latency steers each result back to its issuer.
module mult_share_arbiter #(
    parameter int unsigned MULT_OPS   = 60,
    parameter int unsigned IN_DATA_BW = 8,
    parameter int unsigned MULT_DELAY = 3,
    parameter int unsigned NUM_REQ    = 2,
    localparam int unsigned OpW       = MULT_OPS * IN_DATA_BW,
    localparam int unsigned ResW      = 2 * OpW,
    localparam int unsigned IdW       = $clog2(NUM_REQ),
    localparam int unsigned CntW      = $clog2(MULT_DELAY + 2)
) (
    input  logic                       clk,
    input  logic                       areset,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [NUM_REQ*OpW-1:0]     i_in0,
    input  logic [NUM_REQ*OpW-1:0]     i_in1,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic                       o_mult_run,
    output logic [OpW-1:0]             o_mult_in0,
    output logic [OpW-1:0]             o_mult_in1,
    input  logic                       i_mult_valid,
    input  logic [ResW-1:0]            i_mult_result,
    output logic [NUM_REQ-1:0]         o_valid,
    output logic [ResW-1:0]            o_result,
    output logic [CntW-1:0]            o_inflight,
    output logic                       o_idle,
    output logic                       o_err
);

    logic [IdW-1:0]  rr_ptr_q;
    logic [IdW-1:0]  grant_id, cand;
    logic            grant_any;
    logic [NUM_REQ-1:0] grant;

    logic            run_q;
    logic [IdW-1:0]  issue_id_q;
    logic [OpW-1:0]  mult_in0_q, mult_in1_q;

    logic [MULT_DELAY-1:0] tag_v_q;
    logic [IdW-1:0]        tag_id_q [MULT_DELAY];
    logic                  tag_v_last;
    logic [IdW-1:0]        tag_id_last;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            underflow, mismatch;
    logic            err_q, err_d;

    // Search from the requester after the last grant; reset blocks any grant.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            cand = IdW'((int'(rr_ptr_q) + i) % int'(NUM_REQ));
            if (!grant_any && i_req[cand]) begin
                grant_any   = 1'b1;
                grant_id    = cand;
                grant[cand] = 1'b1;
            end
        end
        if (areset) begin
            grant     = '0;
            grant_any = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            rr_ptr_q   <= IdW'(NUM_REQ - 1);
            run_q      <= 1'b0;
            issue_id_q <= '0;
            mult_in0_q <= '0;
            mult_in1_q <= '0;
        end else begin
            run_q <= grant_any;
            if (grant_any) begin
                rr_ptr_q   <= grant_id;
                issue_id_q <= grant_id;
                mult_in0_q <= i_in0[int'(grant_id)*OpW +: OpW];
                mult_in1_q <= i_in1[int'(grant_id)*OpW +: OpW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            tag_v_q <= '0;
            for (int k = 0; k < int'(MULT_DELAY); k++) tag_id_q[k] <= '0;
        end else begin
            tag_v_q     <= {tag_v_q[MULT_DELAY-2:0], run_q};
            tag_id_q[0] <= issue_id_q;
            for (int k = 1; k < int'(MULT_DELAY); k++) tag_id_q[k] <= tag_id_q[k-1];
        end
    end

    assign tag_v_last  = tag_v_q[MULT_DELAY-1];
    assign tag_id_last = tag_id_q[MULT_DELAY-1];

    always_comb begin
        cnt_d     = cnt_q;
        underflow = 1'b0;
        case ({run_q, i_mult_valid})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01: begin
                if (cnt_q == '0) underflow = 1'b1;
                else             cnt_d = cnt_q - CntW'(1);
            end
            default: cnt_d = cnt_q;
        endcase
        mismatch = i_mult_valid ^ tag_v_last;
        err_d    = err_q | mismatch | underflow;
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        o_valid = '0;
        if (i_mult_valid && tag_v_last) o_valid[tag_id_last] = 1'b1;
    end

    assign o_grant    = grant;
    assign o_mult_run = run_q;
    assign o_mult_in0 = mult_in0_q;
    assign o_mult_in1 = mult_in1_q;
    assign o_result   = i_mult_result;
    assign o_inflight = cnt_q;
    assign o_idle     = (i_req == '0) && (cnt_q == '0);
    assign o_err      = err_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: behavioural multiplier plus a result scoreboard
// keyed on requester id, product lanes and arrival cycle.
module tb_mult_share_arbiter;

    localparam int unsigned MULT_OPS   = 60;
    localparam int unsigned IN_DATA_BW = 8;
    localparam int unsigned MULT_DELAY = 3;
    localparam int unsigned NUM_REQ    = 2;
    localparam int unsigned OpW        = MULT_OPS * IN_DATA_BW;
    localparam int unsigned ResW       = 2 * OpW;
    localparam int unsigned CntW       = $clog2(MULT_DELAY + 2);
    localparam int unsigned RW         = 2 * IN_DATA_BW;

    logic                   clk, areset;
    logic [NUM_REQ-1:0]     i_req;
    logic [NUM_REQ*OpW-1:0] i_in0, i_in1;
    logic [NUM_REQ-1:0]     o_grant;
    logic                   o_mult_run;
    logic [OpW-1:0]         o_mult_in0, o_mult_in1;
    logic                   i_mult_valid;
    logic [ResW-1:0]        i_mult_result;
    logic [NUM_REQ-1:0]     o_valid;
    logic [ResW-1:0]        o_result;
    logic [CntW-1:0]        o_inflight;
    logic                   o_idle, o_err;
    logic                   force_valid;

    mult_share_arbiter #(
        .MULT_OPS(MULT_OPS), .IN_DATA_BW(IN_DATA_BW), .MULT_DELAY(MULT_DELAY), .NUM_REQ(NUM_REQ)
    ) dut (
        .clk(clk), .areset(areset), .i_req(i_req), .i_in0(i_in0), .i_in1(i_in1),
        .o_grant(o_grant), .o_mult_run(o_mult_run), .o_mult_in0(o_mult_in0),
        .o_mult_in1(o_mult_in1), .i_mult_valid(i_mult_valid), .i_mult_result(i_mult_result),
        .o_valid(o_valid), .o_result(o_result), .o_inflight(o_inflight), .o_idle(o_idle),
        .o_err(o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier, reset by the same areset.
    function automatic logic [ResW-1:0] mult_vec(input logic [OpW-1:0] a, input logic [OpW-1:0] b);
        logic [ResW-1:0] r;
        for (int l = 0; l < int'(MULT_OPS); l++)
            r[l*RW +: RW] = RW'($signed(a[l*IN_DATA_BW +: IN_DATA_BW])
                                * $signed(b[l*IN_DATA_BW +: IN_DATA_BW]));
        return r;
    endfunction

    logic [MULT_DELAY-1:0] mv_q;
    logic [ResW-1:0]       mr_q [MULT_DELAY];

    always @(posedge clk) begin
        if (areset) begin
            mv_q <= '0;
            for (int k = 0; k < int'(MULT_DELAY); k++) mr_q[k] <= '0;
        end else begin
            mv_q    <= {mv_q[MULT_DELAY-2:0], o_mult_run};
            mr_q[0] <= mult_vec(o_mult_in0, o_mult_in1);
            for (int k = 1; k < int'(MULT_DELAY); k++) mr_q[k] <= mr_q[k-1];
        end
    end

    assign i_mult_valid  = mv_q[MULT_DELAY-1] | force_valid;
    assign i_mult_result = mr_q[MULT_DELAY-1];

    typedef struct {
        int           id;
        logic [RW-1:0] l0;
        logic [RW-1:0] ll;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   total, bad, cyc, peak;

    task automatic set_ops(input int r, input int a, input int b);
        for (int l = 0; l < int'(MULT_OPS); l++) begin
            i_in0[(r*int'(MULT_OPS)+l)*int'(IN_DATA_BW) +: IN_DATA_BW] = IN_DATA_BW'(a);
            i_in1[(r*int'(MULT_OPS)+l)*int'(IN_DATA_BW) +: IN_DATA_BW] =
                (l == int'(MULT_OPS) - 1) ? IN_DATA_BW'(-b) : IN_DATA_BW'(b);
        end
    endtask

    task automatic push(input int id, input int a, input int b);
        exp_t e;
        e.id  = id;
        e.l0  = RW'(a * b);
        e.ll  = RW'(-(a * b));
        e.due = cyc + 1 + int'(MULT_DELAY);
        sb.push_back(e);
    endtask

    // Samples at the negedge and retires any returning result against the scoreboard.
    task automatic sample();
        exp_t e;
        logic [NUM_REQ-1:0] ev;
        @(negedge clk);
        if (int'(o_inflight) > peak) peak = int'(o_inflight);
        if (sb.size() > 0 && sb[0].due < cyc) begin
            total++; bad++;
            $display("FAIL missing_valid id=%0d due=%0d now=%0d", sb[0].id, sb[0].due, cyc);
            void'(sb.pop_front());
        end
        if (o_valid != '0) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid got=%b want=none cyc=%0d", o_valid, cyc);
            end else begin
                e  = sb.pop_front();
                ev = NUM_REQ'(1) << e.id;
                if (o_valid !== ev || o_result[RW-1:0] !== e.l0
                    || o_result[(MULT_OPS-1)*RW +: RW] !== e.ll || cyc != e.due) begin
                    bad++;
                    $display("FAIL result got valid=%b l0=%h ll=%h cyc=%0d want valid=%b l0=%h ll=%h cyc=%0d",
                             o_valid, o_result[RW-1:0], o_result[(MULT_OPS-1)*RW +: RW], cyc,
                             ev, e.l0, e.ll, e.due);
                end
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() > 0; k++) begin
            sample();
            advance();
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout pending=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        i_req  = '0;
        sample();
        advance();
        areset = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        areset = 1'b1;
        i_req  = '1;
        set_ops(0, 9, 9);
        set_ops(1, 9, 9);
        sample();
        total++;
        if (o_grant !== '0) begin bad++; $display("FAIL reset_prio_grant got=%b want=00", o_grant); end
        advance();
        sample();
        advance();
        areset = 1'b0;
        i_req  = '0;
        sample();
        total++;
        if (o_mult_run !== 1'b0) begin bad++; $display("FAIL rst_run got=%b want=0", o_mult_run); end
        total++;
        if (o_mult_in0 !== '0 || o_mult_in1 !== '0) begin
            bad++; $display("FAIL rst_ops got=%h/%h want=0", o_mult_in0[7:0], o_mult_in1[7:0]);
        end
        total++;
        if (o_valid !== '0) begin bad++; $display("FAIL rst_valid got=%b want=00", o_valid); end
        total++;
        if (o_inflight !== '0) begin bad++; $display("FAIL rst_inflight got=%0d want=0", o_inflight); end
        total++;
        if (o_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", o_err); end
        total++;
        if (o_idle !== 1'b1) begin bad++; $display("FAIL rst_idle got=%b want=1", o_idle); end
        advance();
    endtask

    task automatic test_single();
        set_ops(0, 3, -4);
        i_req = 2'b01;
        sample();
        total++;
        if (o_grant !== 2'b01) begin bad++; $display("FAIL single_grant got=%b want=01", o_grant); end
        push(0, 3, -4);
        advance();
        i_req = '0;
        sample();
        total++;
        if (o_mult_run !== 1'b1) begin bad++; $display("FAIL single_run got=%b want=1", o_mult_run); end
        total++;
        if (o_mult_in0[7:0] !== 8'd3 || o_mult_in1[7:0] !== 8'hFC) begin
            bad++; $display("FAIL single_ops got=%h/%h want=03/fc", o_mult_in0[7:0], o_mult_in1[7:0]);
        end
        advance();
        drain();
    endtask

    task automatic test_contention();
        logic [NUM_REQ-1:0] eg;
        do_reset();
        peak = 0;
        for (int k = 0; k < 6; k++) begin
            set_ops(0, k + 1, 2);
            set_ops(1, k + 1, 3);
            i_req = 2'b11;
            sample();
            eg = (k % 2 == 0) ? 2'b01 : 2'b10;
            total++;
            if (o_grant !== eg) begin
                bad++; $display("FAIL contention_grant k=%0d got=%b want=%b", k, o_grant, eg);
            end
            push(k % 2, k + 1, (k % 2 == 0) ? 2 : 3);
            advance();
        end
        i_req = '0;
        drain();
        total++;
        if (peak != 3) begin bad++; $display("FAIL contention_peak got=%0d want=3", peak); end
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 5; k++) begin
            set_ops(1, k, 2);
            i_req = 2'b10;
            sample();
            total++;
            if (o_grant !== 2'b10) begin
                bad++; $display("FAIL b2b_grant k=%0d got=%b want=10", k, o_grant);
            end
            total++;
            if (o_mult_run !== (k > 1)) begin
                bad++; $display("FAIL b2b_run k=%0d got=%b want=%b", k, o_mult_run, k > 1);
            end
            push(1, k, 2);
            advance();
        end
        i_req = '0;
        drain();
    endtask

    task automatic test_withdraw();
        set_ops(0, 5, 5);
        set_ops(1, 7, 7);
        i_req = 2'b11;
        sample();
        total++;
        if (o_grant !== 2'b01) begin bad++; $display("FAIL withdraw_first got=%b want=01", o_grant); end
        push(0, 5, 5);
        advance();
        i_req = 2'b00;
        sample();
        total++;
        if (o_grant !== 2'b00) begin bad++; $display("FAIL withdraw_none got=%b want=00", o_grant); end
        advance();
        i_req = 2'b00;
        sample();
        total++;
        if (o_mult_run !== 1'b0) begin bad++; $display("FAIL withdraw_run got=%b want=0", o_mult_run); end
        advance();
        i_req = 2'b11;
        sample();
        total++;
        if (o_grant !== 2'b10) begin bad++; $display("FAIL withdraw_ptr got=%b want=10", o_grant); end
        push(1, 7, 7);
        advance();
        i_req = '0;
        drain();
    endtask

    task automatic test_reset_midflight();
        set_ops(0, 2, 2);
        i_req = 2'b01;
        sample();
        push(0, 2, 2);
        advance();
        sample();
        push(0, 2, 2);
        advance();
        i_req = '0;
        sample();
        advance();
        areset = 1'b1;
        sample();
        total++;
        if (o_inflight !== CntW'(2)) begin
            bad++; $display("FAIL midflight_count got=%0d want=2", o_inflight);
        end
        advance();
        areset = 1'b0;
        sb.delete();
        for (int k = 0; k < 8; k++) begin
            sample();
            advance();
        end
        sample();
        total++;
        if (o_inflight !== '0) begin bad++; $display("FAIL midflight_inflight got=%0d want=0", o_inflight); end
        total++;
        if (o_idle !== 1'b1) begin bad++; $display("FAIL midflight_idle got=%b want=1", o_idle); end
        total++;
        if (o_err !== 1'b0) begin bad++; $display("FAIL midflight_err got=%b want=0", o_err); end
        advance();
    endtask

    task automatic test_mismatch();
        force_valid = 1'b1;
        sample();
        total++;
        if (o_valid !== '0) begin bad++; $display("FAIL mismatch_valid got=%b want=00", o_valid); end
        total++;
        if (o_err !== 1'b0) begin bad++; $display("FAIL mismatch_early got=%b want=0", o_err); end
        advance();
        force_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample();
            total++;
            if (o_err !== 1'b1) begin bad++; $display("FAIL mismatch_sticky k=%0d got=%b want=1", k, o_err); end
            advance();
        end
        do_reset();
        sample();
        total++;
        if (o_err !== 1'b0) begin bad++; $display("FAIL mismatch_clear got=%b want=0", o_err); end
        advance();
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        cyc         = 0;
        peak        = 0;
        areset      = 1'b1;
        i_req       = '0;
        i_in0       = '0;
        i_in1       = '0;
        force_valid = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_withdraw();
        test_reset_midflight();
        test_mismatch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
